// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
// Valid/ready/data handshake bundle used on both sides of a pipe_stage_skid.
//   valid : producer has a payload this cycle
//   ready : consumer accepts this cycle
//   data  : payload, WIDTH bits
// Modports:
//   master : the producer side (drives valid/data, samples ready)
//   slave  : the consumer side (samples valid/data, drives ready)
interface pipe_stage_skid_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Parametrised inter-stage pipeline register with valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-low reset
//   flush     : synchronous kill of all held entries (highest priority)
//   up        : upstream handshake (slave modport: in_valid/in_ready/in_data)
//   dn        : downstream handshake (master modport: out_valid/out_ready/out_data)
//   occupancy : number of held entries (0..2 with skid, 0..1 without)
// Parameters:
//   WIDTH      : payload width
//   SKID_EN    : 1 = main + skid register, registered in_ready
//                0 = single register, combinational in_ready
//   CLEAR_DATA : 1 = data zeroed on reset/flush and bubbles read as zero
module pipe_stage_skid #(
  parameter int WIDTH      = 64,
  parameter int SKID_EN    = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
  output logic [1:0]           occupancy
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid;
  logic             in_ready;
  logic             accept;
  logic             drain;

  assign accept   = up.valid & in_ready;
  assign drain    = main_valid_q & dn.ready;
  assign up.ready = in_ready;

  // A bubble is presented as all-zero when CLEAR_DATA is set.
  assign dn.valid  = main_valid_q;
  assign dn.data   = ((CLEAR_DATA != 0) && !main_valid_q) ? '0 : main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid};

  generate
    if (SKID_EN != 0) begin : g_skid
      logic             skid_valid_q, skid_valid_d;
      logic [WIDTH-1:0] skid_data_q, skid_data_d;

      // in_ready comes straight from a flop: no path from out_ready.
      assign in_ready   = !skid_valid_q;
      assign skid_valid = skid_valid_q;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          if (CLEAR_DATA != 0) begin
            main_data_d = '0;
            skid_data_d = '0;
          end
        end else if (!main_valid_q) begin
          // Skid is never valid while main is empty.
          if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = up.data;
          end
        end else if (drain) begin
          if (accept) begin
            // accept implies skid empty, so the new beat goes straight to main
            main_data_d = up.data;
          end else if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (accept) begin
          // Main stalled: park the new beat; in_ready drops next cycle.
          skid_valid_d = 1'b1;
          skid_data_d  = up.data;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_valid_q <= 1'b0;
        end else begin
          skid_valid_q <= skid_valid_d;
        end
      end

      if (CLEAR_DATA != 0) begin : g_skid_clr
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            skid_data_q <= '0;
          end else begin
            skid_data_q <= skid_data_d;
          end
        end
      end else begin : g_skid_keep
        always_ff @(posedge clk) begin
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_noskid
      assign in_ready   = !main_valid_q | dn.ready;
      assign skid_valid = 1'b0;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
          if (CLEAR_DATA != 0) begin
            main_data_d = '0;
          end
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = up.data;
        end else if (drain) begin
          main_valid_d = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
    end
  end

  generate
    if (CLEAR_DATA != 0) begin : g_main_clr
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_data_q <= '0;
        end else begin
          main_data_q <= main_data_d;
        end
      end
    end else begin : g_main_keep
      always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
      end
    end
  endgenerate

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register; successor to the fixed-width IF->ID register that was driven by a stall vector.
- Replaces the stall vector with a valid/ready handshake and an explicit flush.
- Optional 2-entry skid buffer gives full throughput and registered upstream ready.
- Instantiated between any two pipeline stages (IF->ID, ID->EX, ...), with WIDTH set to that stage's bus width.

Parameters:
WIDTH, 64, payload bus width in bits (>=1)
SKID_EN, 1, 1 = main register plus skid register with registered in_ready; 0 = single register with combinational in_ready
CLEAR_DATA, 1, 1 = data registers are zeroed on reset/flush and out_data is forced to 0 when out_valid=0; 0 = data registers are not reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0); deassertion is synchronised externally
flush  in  1  kill all held entries (branch mispredict / exception)
in_valid  in  1  upstream has a payload
in_ready  out  1  stage can accept this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  stage presents a payload
out_ready  in  1  downstream accepts this cycle
out_data  out  WIDTH  payload to downstream
occupancy  out  2  number of held entries: 0..2 when SKID_EN=1, 0..1 when SKID_EN=0

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (rst=0, async):
  - main_valid = skid_valid = 0.
  - Data registers = 0 when CLEAR_DATA=1.
  - Outputs during reset: out_valid=0, occupancy=0, out_data=0, in_ready=1 (SKID_EN=1) or in_ready=1 (SKID_EN=0, main empty).
- Output gating: out_valid = main_valid; out_data = main_data, forced to 0 when !main_valid and CLEAR_DATA=1 (a bubble is all-zero).
- Latency: a payload accepted at edge N appears on out_* in the cycle after edge N. Throughput is 1 per cycle when out_ready=1.
- Ordering: strict FIFO; the skid entry is always older than any new input.
- SKID_EN=1:
  - in_ready = !skid_valid, registered; there is no in_ready<-out_ready combinational path.
  - main empty & accept -> main<=in.
  - main full & drain & !accept -> main<=skid if skid_valid, else main_valid<=0; skid_valid<=0.
  - main full & drain & accept (skid is necessarily empty) -> main<=in.
  - main full & !drain & accept -> skid<=in; in_ready drops next cycle.
  - main full & !drain & !accept -> hold all state.
- SKID_EN=0:
  - in_ready = !main_valid | out_ready (combinational).
  - accept -> main<=in, else drain -> main_valid<=0, else hold.
  - The skid register is not generated; occupancy[1]=0.
- Flush:
  - Synchronous, highest priority.
  - At the edge where flush=1: main_valid=skid_valid=0, data is zeroed if CLEAR_DATA=1, and any payload presented that cycle is discarded even if accept=1.
  - In the flush cycle, out_valid still reflects the pre-flush state; downstream must ignore it using its own flush.
  - Flush while empty is a no-op.
- Occupancy = main_valid + skid_valid, updated with the valid bits.
- Invariants:
  - skid_valid implies main_valid.
  - in_valid held with in_data stable until accept; out_valid/out_data stable while out_valid & !out_ready.
- Reset mid-transfer: all entries are lost immediately; no partial-beat state remains.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle with 2 entries held -> out_valid=0, occupancy=0, out_data=0 immediately; after release, in_ready=1.
- Streaming (SKID_EN=1, out_ready=1): in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later, no bubbles, occupancy stays 1.
- Backpressure: out_ready=0 while sending 0xA,0xB -> occupancy=2, in_ready=0, 0xC held on input; out_ready=1 -> output order 0xA,0xB,0xC, in_ready returns 1 the cycle after skid drains.
- Flush: 2 entries held, flush=1 with in_valid=1 and in_data=0xD -> next cycle out_valid=0, occupancy=0, out_data=0, and 0xD is never output.
- SKID_EN=0: out_ready toggles 1,0,1 with in_valid=1 -> in_ready follows !main_valid|out_ready combinationally, no payload is lost or duplicated (scoreboard).
- Random: WIDTH=32 and WIDTH=7, 10k cycles of random valid/ready/flush checked against a reference queue model -> zero mismatches, and occupancy never exceeds 2 (SKID_EN=1) or 1 (SKID_EN=0).
